// File: rtl/alu_share_arbiter_pkg.sv
// Shared types, constants and the round-robin pick for the shared-ALU arbiter.
package alu_pkg;

  localparam int ALU_W        = 16;
  localparam int MAX_REQ      = 8;
  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_ILLEGAL = 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_MUL  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_NOT  = 3'b110,
    OP_RSVD = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // First set bit of valid searching upward from last+1, wrapping modulo num.
  // Callers check that some bit is set; otherwise last is returned unchanged.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned last,
                                          input int unsigned num);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = last;
    found = 1'b0;
    for (int unsigned off = 1; off <= MAX_REQ; off++) begin
      idx = (last + off) % num;
      if (!found && (off <= num) && valid[3'(idx)]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the issuing engines and the shared-ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready may depend on valid.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*3-1:0]     req_opcode;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic [1:0]               rsp_flags;

  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

endinterface

// File: rtl/alu_share_arbiter_core.sv
// Purely combinational ALU: add/sub with carry/borrow, bitwise ops, illegal detect.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_e          opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             illegal
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extended difference goes negative exactly when a < b, so its top bit is the borrow.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result  = '0;
    carry   = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU datapath between NUM_REQ requesters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ALU_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus,
  output state_e              dbg_state
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  opcode_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       flags_q, flags_d;

  logic             any_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_illegal;

  assign any_valid = |bus.req_valid;
  assign grant_idx = ID_W'(rr_pick(MAX_REQ'(bus.req_valid), 32'(last_grant_q), NUM_REQ));

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a       (a_q),
    .b       (b_q),
    .opcode  (op_q),
    .result  (alu_result),
    .carry   (alu_carry),
    .illegal (alu_illegal)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    rsp_id_d      = rsp_id_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    result_d      = result_q;
    flags_d       = flags_q;
    bus.req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst so no grant can be seen while reset is held.
        if (any_valid && !rst) begin
          bus.req_ready[grant_idx] = 1'b1;
          op_d         = opcode_e'(bus.req_opcode[3*int'(grant_idx) +: 3]);
          a_d          = bus.req_a[WIDTH*int'(grant_idx) +: WIDTH];
          b_d          = bus.req_b[WIDTH*int'(grant_idx) +: WIDTH];
          last_grant_d = grant_idx;
          rsp_id_d     = grant_idx;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d               = alu_result;
        flags_d                = '0;
        flags_d[FLAG_CARRY]    = alu_carry;
        flags_d[FLAG_ILLEGAL]  = alu_illegal;
        state_d                = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      rsp_id_q     <= '0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
    end
  end

  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 16-bit ALU datapath between NUM_REQ requesters. Round-robin arbitration, a valid/ready request handshake, registered operands and result, and a response channel tagged with the requester ID. It sits between the issuing engines and a single combinational ALU core. The datapath is used for exactly one request at a time.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_opcode  in  NUM_REQ*3  packed opcodes, requester i at [3i+2:3i]
- req_a  in  NUM_REQ*WIDTH  packed operand A
- req_b  in  NUM_REQ*WIDTH  packed operand B
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high per cycle
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester served
- rsp_result  out  WIDTH  ALU result
- rsp_flags  out  2  [0] carry-out (ADD) or borrow (SUB); [1] illegal opcode

## Operation
- Opcodes: 000 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT (A only).
- 001 (MUL) and 111 are illegal in this block. They produce result 0 and flags=2'b10.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant the first valid requester searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready for the granted requester is high combinationally in that same cycle.
  - Latch opcode, A and B, and the grant index into last_grant/rsp_id.
  - Go to EXEC.
  - If no request is valid, stay in IDLE and keep all req_ready low.
- EXEC:
  - Drive the latched operands into the ALU core.
  - Register result and flags.
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_flags hold stable.
  - When rsp_valid && rsp_ready, go to IDLE.
  - req_ready stays low throughout.
- Arithmetic:
  - ADD: result = (A+B) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: result = (A-B) mod 2^WIDTH; borrow = (A<B) unsigned.
  - Logic ops and NOT: flags[0]=0.
- A requester whose req_valid drops before it is granted is simply skipped. The arbiter keeps no memory of it.

## Timing
- Reset values:
  - state=IDLE
  - last_grant=NUM_REQ-1, so requester 0 has first priority
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0
  - req_ready=0
- Latency: handshake in cycle t gives rsp_valid high from cycle t+2.
- Minimum occupancy per request is 3 cycles when rsp_ready is held high, i.e. 1 request per 3 cycles.
- Back-pressure: rsp_ready low holds RESP indefinitely with outputs stable. No new grants are made while in RESP.
- Simultaneous requests: exactly one grant. The others keep valid and win in round-robin order on later IDLE cycles.
- Wrap-around: after granting NUM_REQ-1, the search starts again at 0.
- Reset mid-operation (EXEC or RESP): the transaction is dropped and no response is emitted. All outputs go to reset values immediately (asynchronous).

## Structure
- Shared package alu_pkg:
  - opcode enum (OP_ADD..OP_NOT, plus the MUL and reserved codes)
  - FSM state enum
  - ALU_W=16
  - flag bit-index constants
- Sub-module alu_core: purely combinational. Inputs A, B and opcode. Outputs result, carry/borrow and illegal. Instantiated once.
- The round-robin pick is a function in alu_pkg, not a separate module.

## Test plan
- Reset then single request:
  - Stimulus: requester 2 sends ADD, A=16'hFFFF, B=16'h0001.
  - Response: req_ready[2] high in that cycle; two cycles later rsp_valid with id=2, result=16'h0000, flags=2'b01.
- Fairness:
  - Stimulus: all 4 requesters valid continuously, rsp_ready=1.
  - Response: grant order 0,1,2,3,0,1; a grant every 3 cycles.
- Back-pressure:
  - Stimulus: SUB A=5, B=7 with rsp_ready=0 for 5 cycles.
  - Response: rsp_valid held with result=16'hFFFE, flags=2'b01; no req_ready pulses until the cycle after rsp_ready=1.
- Illegal opcode:
  - Stimulus: opcode 001, A=3, B=4.
  - Response: result=0, flags=2'b10; the next request is served normally.
- Logic ops:
  - Stimulus: AND/OR/XOR/NOT on A=16'hF0F0, B=16'h0FF0.
  - Response: results 16'h00F0, 16'hFFF0, 16'hFF00, 16'h0F0F respectively, flags=2'b00.
- Reset during RESP:
  - Stimulus: assert rst while rsp_valid=1.
  - Response: rsp_valid drops the same cycle; after release, requester 0 has priority again.
